// File: rtl/ddr_pkg.sv
// Shared DDR controller definitions: refresh FSM states and default refresh timing.
package ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RFC
  } ref_state_e;

  localparam int TREFI_DEF    = 780;
  localparam int TRFC_DEF     = 11;
  localparam int MAX_PEND_DEF = 8;

  // Counter width for a terminal count of n; a count of 1 still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_ref_timer.sv
// Terminal-count timer: counts 0..N-1 while enabled, pulses done_o on the last count and wraps.
module ddr_ref_timer
  import ddr_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int            W    = cnt_w(N);
  localparam logic [W-1:0]  LAST = W'(N - 1);

  logic [W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign done_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/ddr_refresh_sched.sv
// DDR refresh scheduler: tracks owed refreshes per tREFI, requests them opportunistically
// or urgently, and holds off other commands for tRFC after each issued REFRESH.
module ddr_refresh_sched
  import ddr_pkg::*;
#(
  parameter int TREFI_CYCLES = TREFI_DEF,
  parameter int TRFC_CYCLES  = TRFC_DEF,
  parameter int MAX_PEND     = MAX_PEND_DEF
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       en_i,
  input  logic       idle_i,
  input  logic       ref_ack_i,
  output logic       ref_req_o,
  output logic       busy_o,
  output logic       urgent_o,
  output logic [3:0] pend_o,
  output logic       ovf_o
);

  localparam logic [3:0] PEND_MAX  = 4'(MAX_PEND);
  localparam logic [3:0] URGENT_TH = 4'(MAX_PEND - 1);

  ref_state_e state_q;
  logic [3:0] pend_q;
  logic       tick;
  logic       rfc_done;
  logic       ack_in_req;

  ddr_ref_timer #(.N(TREFI_CYCLES)) u_interval (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (en_i),
    .clr_i    (~en_i),
    .done_o   (tick)
  );

  ddr_ref_timer #(.N(TRFC_CYCLES)) u_rfc (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (state_q == ST_RFC),
    .clr_i    (state_q != ST_RFC),
    .done_o   (rfc_done)
  );

  assign ack_in_req = ref_ack_i & (state_q == ST_REQ);

  // A tick cancelled by a same-cycle ack is not lost, so only an uncancelled tick at saturation overflows.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_q <= '0;
      ovf_o  <= 1'b0;
    end else if (tick && !ack_in_req) begin
      if (pend_q == PEND_MAX) ovf_o  <= 1'b1;
      else                    pend_q <= pend_q + 4'd1;
    end else if (ack_in_req && !tick) begin
      pend_q <= pend_q - 4'd1;
    end
  end

  assign urgent_o = (pend_q >= URGENT_TH);
  assign pend_o   = pend_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      ref_req_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (pend_q != 4'd0 && (idle_i || urgent_o)) begin
          state_q   <= ST_REQ;
          ref_req_o <= 1'b1;
        end
        ST_REQ: if (ref_ack_i) begin
          state_q   <= ST_RFC;
          ref_req_o <= 1'b0;
          busy_o    <= 1'b1;
        end
        ST_RFC: if (rfc_done) begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          ref_req_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_refresh_sched.sv
// Self-checking bench for ddr_refresh_sched: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ddr_refresh_sched;

  localparam int TREFI = 16;
  localparam int TRFC  = 4;
  localparam int MAXP  = 4;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       en_i = 1'b0;
  logic       idle_i = 1'b0;
  logic       ref_ack_i = 1'b0;
  logic       ref_req_o;
  logic       busy_o;
  logic       urgent_o;
  logic [3:0] pend_o;
  logic       ovf_o;

  int checks   = 0;
  int failures = 0;

  ddr_refresh_sched #(
    .TREFI_CYCLES (TREFI),
    .TRFC_CYCLES  (TRFC),
    .MAX_PEND     (MAXP)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .en_i      (en_i),
    .idle_i    (idle_i),
    .ref_ack_i (ref_ack_i),
    .ref_req_o (ref_req_o),
    .busy_o    (busy_o),
    .urgent_o  (urgent_o),
    .pend_o    (pend_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: refresh debt, an outstanding request flag and a tRFC countdown.
  int m_age;
  int m_pend;
  int m_rfc_left;
  bit m_req;
  bit m_ovf;

  always @(posedge clk_i or negedge reset_ni) begin : model
    bit tick;
    bit ack_ok;
    bit urgent;
    int p0;
    if (!reset_ni) begin
      m_age      = 0;
      m_pend     = 0;
      m_rfc_left = 0;
      m_req      = 0;
      m_ovf      = 0;
    end else begin
      p0     = m_pend;
      tick   = en_i && (m_age == TREFI - 1);
      ack_ok = ref_ack_i && m_req;
      urgent = (p0 >= MAXP - 1);
      if (tick && !ack_ok) begin
        if (m_pend == MAXP) m_ovf = 1;
        else                m_pend = m_pend + 1;
      end else if (ack_ok && !tick) begin
        m_pend = m_pend - 1;
      end
      if (m_rfc_left > 0) begin
        m_rfc_left = m_rfc_left - 1;
      end else if (m_req) begin
        if (ref_ack_i) begin
          m_req      = 0;
          m_rfc_left = TRFC;
        end
      end else if (p0 > 0 && (idle_i || urgent)) begin
        m_req = 1;
      end
      m_age = !en_i ? 0 : (tick ? 0 : m_age + 1);
    end
  end

  always @(negedge clk_i) begin
    if (reset_ni) begin
      check("cmp_ref_req", 32'(ref_req_o), 32'(m_req));
      check("cmp_busy",    32'(busy_o),    32'(m_rfc_left > 0));
      check("cmp_urgent",  32'(urgent_o),  32'(m_pend >= MAXP - 1));
      check("cmp_pend",    32'(pend_o),    m_pend);
      check("cmp_ovf",     32'(ovf_o),     32'(m_ovf));
    end
  end

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_ni  = 1'b0;
    en_i      = 1'b0;
    idle_i    = 1'b0;
    ref_ack_i = 1'b0;
    cyc();
    cyc();
    reset_ni = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    // Reset state
    repeat (2) cyc();
    check("rst_ref_req", 32'(ref_req_o), 0);
    check("rst_busy",    32'(busy_o),    0);
    check("rst_urgent",  32'(urgent_o),  0);
    check("rst_pend",    32'(pend_o),    0);
    check("rst_ovf",     32'(ovf_o),     0);
    reset_ni = 1'b1;

    // First request latency, ack two cycles later, tRFC window length
    en_i   = 1'b1;
    idle_i = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!ref_req_o && n < 100);
    check("first_req_latency", n, 17);
    cyc();
    ref_ack_i = 1'b1;
    cyc();
    ref_ack_i = 1'b0;
    n = 0;
    while (busy_o && n < 50) begin n++; cyc(); end
    check("busy_len", n, 4);
    check("pend_drained", 32'(pend_o), 0);

    // No acks: accumulation, urgency, saturation and sticky overflow
    do_reset();
    en_i = 1'b1;
    for (int e = 0; e < 80; e++) begin
      cyc();
      case (e)
        15: check("pend_tick1", 32'(pend_o), 1);
        31: begin
          check("pend_tick2", 32'(pend_o), 2);
          check("urgent_at2", 32'(urgent_o), 0);
        end
        47: begin
          check("pend_tick3", 32'(pend_o), 3);
          check("urgent_at3", 32'(urgent_o), 1);
          check("req_before_urgent", 32'(ref_req_o), 0);
        end
        48: check("req_after_urgent", 32'(ref_req_o), 1);
        63: begin
          check("pend_sat", 32'(pend_o), 4);
          check("ovf_before", 32'(ovf_o), 0);
        end
        79: begin
          check("pend_held_sat", 32'(pend_o), 4);
          check("ovf_set", 32'(ovf_o), 1);
        end
        default: ;
      endcase
    end
    ref_ack_i = 1'b1;
    cyc();
    ref_ack_i = 1'b0;
    check("pend_after_ack", 32'(pend_o), 3);
    check("ovf_sticky", 32'(ovf_o), 1);

    // Ack coincident with a tick at pend=2
    do_reset();
    en_i = 1'b1;
    for (int e = 0; e < 47; e++) begin
      cyc();
      if (e == 31) begin
        check("pend_pre_coinc", 32'(pend_o), 2);
        idle_i = 1'b1;
      end
      if (e == 32) check("req_opportunistic", 32'(ref_req_o), 1);
      if (e == 46) ref_ack_i = 1'b1;
    end
    cyc();
    ref_ack_i = 1'b0;
    check("coinc_pend", 32'(pend_o), 2);
    check("coinc_busy", 32'(busy_o), 1);
    check("coinc_req",  32'(ref_req_o), 0);

    // Asynchronous reset mid-tRFC
    cyc();
    #2 reset_ni = 1'b0;
    #1;
    check("arst_ref_req", 32'(ref_req_o), 0);
    check("arst_busy",    32'(busy_o),    0);
    check("arst_urgent",  32'(urgent_o),  0);
    check("arst_pend",    32'(pend_o),    0);
    check("arst_ovf",     32'(ovf_o),     0);
    @(negedge clk_i);
    #1 reset_ni = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!ref_req_o && n < 100);
    check("req_latency_after_reset", n, 17);

    // en_i dropped in REQ, acks outside REQ ignored
    en_i = 1'b0;
    repeat (20) cyc();
    check("req_held_en_low", 32'(ref_req_o), 1);
    check("pend_held_en_low", 32'(pend_o), 1);
    ref_ack_i = 1'b1;
    cyc();
    ref_ack_i = 1'b0;
    check("ack_en_low_pend", 32'(pend_o), 0);
    cyc();
    ref_ack_i = 1'b1;
    cyc();
    ref_ack_i = 1'b0;
    check("ack_in_rfc_pend", 32'(pend_o), 0);
    check("ack_in_rfc_busy", 32'(busy_o), 1);
    repeat (6) cyc();
    ref_ack_i = 1'b1;
    cyc();
    ref_ack_i = 1'b0;
    check("ack_in_idle_pend", 32'(pend_o), 0);
    check("ack_in_idle_req",  32'(ref_req_o), 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (i == 2000) do_reset();
      en_i   = ($urandom % 32) != 0;
      idle_i = ($urandom % 4) == 0;
      case ((i / 200) % 3)
        0:       ref_ack_i = ($urandom % 3) == 0;
        1:       ref_ack_i = 1'b0;
        default: ref_ack_i = ($urandom % 2) == 0;
      endcase
    end
    ref_ack_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_refresh_sched.md
DDR_REFRESH_SCHED -- requirements
Module: ddr_refresh_sched

Interface
REQ-001 SHALL have parameter TREFI_CYCLES, default 780, refresh interval in clk_i cycles (>=2).
REQ-002 SHALL have parameter TRFC_CYCLES, default 11, refresh recovery time in clk_i cycles (>=1).
REQ-003 SHALL have parameter MAX_PEND, default 8, maximum number of postponed refreshes (2..15).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en_i, input, 1, refresh timekeeping enable, asserted after DDR init completes.
REQ-007 SHALL have port idle_i, input, 1, command sequencer idle, so an opportunistic refresh is allowed.
REQ-008 SHALL have port ref_ack_i, input, 1, sequencer has issued the REFRESH command this cycle.
REQ-009 SHALL have port ref_req_o, output, 1, refresh request to the command sequencer.
REQ-010 SHALL have port busy_o, output, 1, tRFC window active, so no other DDR command is allowed.
REQ-011 SHALL have port urgent_o, output, 1, pending count >= MAX_PEND-1, so the sequencer must drain.
REQ-012 SHALL have port pend_o, output, 4, current pending-refresh count.
REQ-013 SHALL have port ovf_o, output, 1, sticky error: a refresh tick was lost at saturation.

Function
REQ-014 SHALL count an interval counter up by 1 each cycle while en_i=1; value TREFI_CYCLES-1 is a tick: counter wraps to 0 next cycle.
REQ-015 SHALL hold the interval counter at 0 while en_i=0; pending count and FSM are unaffected.
REQ-016 SHALL increment pend on a tick; on a tick when pend=MAX_PEND, SHALL hold pend and set ovf_o.
REQ-017 SHALL decrement pend by 1 on ref_ack_i while in REQ; a simultaneous tick and ack SHALL leave pend unchanged.
REQ-018 SHALL implement FSM states IDLE, REQ, RFC.
REQ-019 IDLE->REQ SHALL occur when pend>0 and (idle_i=1 or urgent_o=1); ref_req_o=1 from the next cycle.
REQ-020 In REQ, ref_req_o SHALL stay 1 until ref_ack_i; it SHALL never be withdrawn, even if idle_i or en_i drops.
REQ-021 REQ->RFC SHALL occur on ref_ack_i; ref_req_o=0 in the following cycle.
REQ-022 In RFC, busy_o SHALL be 1 for exactly TRFC_CYCLES cycles, then return to IDLE; there SHALL be no back-to-back REQ without at least one IDLE cycle.
REQ-023 ref_ack_i outside REQ SHALL be ignored: no pend change and no state change.
REQ-024 ref_req_o, busy_o, urgent_o, pend_o and ovf_o SHALL be registered or decoded from registers only; there SHALL be no combinational input-to-output path.
REQ-025 Counter widths SHALL be $clog2 of each parameter; arithmetic SHALL be unsigned with no wrap beyond the specified terminal counts.

Reset
REQ-026 reset_ni=0 SHALL asynchronously force: FSM=IDLE, interval=0, rfc counter=0, pend=0, ovf_o=0, ref_req_o=0, busy_o=0, urgent_o=0.
REQ-027 Reset mid-REQ or mid-RFC SHALL abandon the operation; the owed refresh is not remembered.
REQ-028 Reset deassertion SHALL take effect on the first clk_i edge after release; ovf_o SHALL be cleared only by reset.

Structure
REQ-029 The shared package ddr_pkg SHALL hold the FSM state enum ref_state_e and default timing constants (TREFI_DEF, TRFC_DEF, MAX_PEND_DEF).
REQ-030 SHALL use one sub-module, ddr_ref_timer: a parameterised terminal-count timer with async active-low reset, enable, sync clear and done pulse, instantiated twice (interval and tRFC).

Verification (bench params TREFI=16, TRFC=4, MAX_PEND=4)
REQ-031 en_i=1, idle_i=1, ack 2 cycles after req -> first ref_req_o 17 cycles after en_i rises, busy_o high exactly 4 cycles, pend returns to 0.
REQ-032 idle_i=0, no ack for 48 cycles -> pend 1,2,3 at ticks; urgent_o=1 at pend=3; ref_req_o asserted the cycle after urgent_o rises.
REQ-033 idle_i=0, no ack for 80 cycles -> pend saturates at 4, ovf_o=1 on the 5th tick and stays 1 after a later ack.
REQ-034 ack coincident with tick at pend=2 -> pend stays 2, FSM to RFC.
REQ-035 reset_ni pulsed low mid-RFC, asynchronous to clk_i -> all outputs 0 immediately, FSM restarts from IDLE with interval 0.
REQ-036 ref_ack_i pulsed in IDLE and RFC; en_i dropped during REQ -> no pend change, ref_req_o held until ack.
